lo_monitor: RTL

Digital observer for the local-oscillator pair that `mixer_control` drives into the Gilbert cell. It samples `lo_p`/`lo_n` in the `clk` domain, measures the `lo_p` period and high time in clock cycles, and declares lock when the period is stable. It also raises sticky faults for overlapping LO phases and for a stalled LO. The results are muxed onto `uo_out` at top level, so the LO path can be verified on silicon without probing the analog pins.

---
 rtl/mixer_pkg.sv | 14 +
 rtl/sync_2ff.sv | 33 +++
 rtl/lo_monitor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared types and constants for the mixer control blocks.
// Holds the LO monitor state encoding and its default counter width.
// No logic; no latency or backpressure of its own.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } lo_mon_state_t;

    localparam int LO_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for an asynchronous level input.
// Latency: 2 clk edges from capture to q.
// Backpressure: none; free-running sampler.
module sync_2ff (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/lo_monitor.sv
// LO pair observer: measures lo_p period/high time, tracks lock, flags overlap and stall.
// Latency: a lo_p rise captured at edge k updates period/valid at edge k+2.
// Backpressure: none; valid is a one-cycle report pulse with no ready.
module lo_monitor
    import mixer_pkg::*;
#(
    parameter int CNT_W   = LO_CNT_W,
    parameter int OVL_MIN = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             lo_p,
    input  logic             lo_n,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             fault_overlap,
    output logic             fault_stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int               OVL_W   = $clog2(OVL_MIN + 1);
    localparam logic [OVL_W-1:0] OVL_SAT = OVL_W'(OVL_MIN);

    logic sp;
    logic sn;

    sync_2ff u_sync_p (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (lo_p),
        .q     (sp)
    );

    sync_2ff u_sync_n (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (lo_n),
        .q     (sn)
    );

    lo_mon_state_t    state_q, state_d;
    logic             sp_d_q, sp_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic [OVL_W-1:0] ovl_cnt_q, ovl_cnt_d;
    logic             fault_overlap_q, fault_overlap_d;
    logic             fault_stuck_q, fault_stuck_d;

    logic             rise;
    logic             fall;
    logic             both_hi;
    logic             ovl_set;
    logic             stuck_set;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] diff;

    assign rise    = sp & ~sp_d_q;
    assign fall    = ~sp & sp_d_q;
    assign both_hi = sp & sn;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    // max - min keeps the difference unsigned without wrap
    assign diff    = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);

    always_comb begin
        state_d     = state_q;
        sp_d_d      = sp;
        cnt_d       = cnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        stuck_set   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = ARMED;
                end
            end
            ARMED, MEASURE: begin
                // a rise coinciding with saturation wins over the stall
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    cnt_d    = CNT_ONE;
                    state_d  = MEASURE;
                    locked_d = (state_q == MEASURE) && (diff <= CNT_ONE);
                end else if (cnt_q == CNT_MAX) begin
                    stuck_set = 1'b1;
                    locked_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d    = '0;
                locked_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        if ((state_q != IDLE) && fall) begin
            high_time_d = cnt_q;
        end
    end

    always_comb begin
        ovl_cnt_d = '0;
        if (both_hi) begin
            ovl_cnt_d = (ovl_cnt_q == OVL_SAT) ? ovl_cnt_q : ovl_cnt_q + OVL_W'(1);
        end
        // fires on the cycle the run of overlap reaches OVL_MIN
        ovl_set         = both_hi && (ovl_cnt_q >= (OVL_SAT - OVL_W'(1)));
        fault_overlap_d = (fault_overlap_q & ~clear) | ovl_set;
        fault_stuck_d   = (fault_stuck_q & ~clear) | stuck_set;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            sp_d_q          <= 1'b0;
            cnt_q           <= '0;
            period_q        <= '0;
            high_time_q     <= '0;
            valid_q         <= 1'b0;
            locked_q        <= 1'b0;
            ovl_cnt_q       <= '0;
            fault_overlap_q <= 1'b0;
            fault_stuck_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            sp_d_q          <= sp_d_d;
            cnt_q           <= cnt_d;
            period_q        <= period_d;
            high_time_q     <= high_time_d;
            valid_q         <= valid_d;
            locked_q        <= locked_d;
            ovl_cnt_q       <= ovl_cnt_d;
            fault_overlap_q <= fault_overlap_d;
            fault_stuck_q   <= fault_stuck_d;
        end
    end

    assign period        = period_q;
    assign high_time     = high_time_q;
    assign valid         = valid_q;
    assign locked        = locked_q;
    assign fault_overlap = fault_overlap_q;
    assign fault_stuck   = fault_stuck_q;

endmodule
